mdrp_responder: RTL and testbench
=================================

MDRP_RESPONDER -- requirements
Module: mdrp_responder

Interface
REQ-001 SHALL have parameter LOCK_DELAY, default 1000: I_MD_CLK cycles from PLL reset release to lock.
REQ-002 SHALL have parameter GOOD_MASK, default 8'h88: bit k set means ICP code k (reg 0x11[2:0]) can lock.
REQ-003 SHALL have port I_MD_CLK, input, 1 bit: single clock for all logic.
REQ-004 SHALL have port I_RST_N, input, 1 bit: asynchronous, active-low reset.
REQ-005 SHALL have port I_PLL_RST, input, 1 bit: modelled PLL reset, high means held in reset.
REQ-006 SHALL have port I_MD_INC, input, 1 bit: address auto-increment strobe.
REQ-007 SHALL have port I_MD_OPC, input, 2 bits: 00 nop, 01 write, 10 read, 11 illegal.
REQ-008 SHALL have port I_MD_WR_DATA, input, 8 bits: write data.
REQ-009 SHALL have port O_MD_RD_DATA, output, 8 bits: read data.
REQ-010 SHALL have port O_LOCK, output, 1 bit: modelled PLL lock.
REQ-011 SHALL have port O_ERR_CNT, output, 8 bits: protocol error count.

Function
REQ-012 SHALL hold an 8-bit address pointer; I_MD_INC high increments it by 1 at the clock edge, wrapping 255->0.
REQ-013 SHALL clear the address pointer on the cycle after I_PLL_RST changes level, in either direction; the clear overrides I_MD_INC.
REQ-014 SHALL implement a 32-entry x 8-bit register file, indices 0x00-0x1F.
REQ-015 OPC=01 SHALL write I_MD_WR_DATA to reg[addr]; writes with addr>=0x20 are ignored.
REQ-016 OPC=10 SHALL register reg[addr] onto O_MD_RD_DATA with 1-cycle latency; addr>=0x20 returns 8'h00.
REQ-017 For OPC=00 or 11, O_MD_RD_DATA SHALL hold its last value.
REQ-018 When INC and OPC occur in the same cycle, the access SHALL use the pre-increment address.
REQ-019 A read of the address written in the previous cycle SHALL return the new data.
REQ-020 Lock FSM SHALL have states RESET, COUNT, LOCKED and FAIL.
REQ-021 Lock FSM: while I_PLL_RST=1 it SHALL stay in RESET; on I_PLL_RST=0 it SHALL go RESET->COUNT with the counter cleared.
REQ-022 COUNT SHALL move to LOCKED when the counter reaches LOCK_DELAY-1 and GOOD_MASK[reg[0x11][2:0]]=1; otherwise it SHALL move to FAIL.
REQ-023 O_LOCK SHALL be 1 only in LOCKED.
REQ-024 In any state, I_PLL_RST=1 SHALL return the FSM to RESET next cycle, dropping O_LOCK that cycle.
REQ-025 A write (OPC=01) while in COUNT, LOCKED or FAIL SHALL restart COUNT with the counter cleared.
REQ-026 The lock counter SHALL be clog2(LOCK_DELAY+1) bits wide and SHALL saturate, never wrap.

Reset
REQ-027 I_RST_N=0 SHALL asynchronously set: address 0, O_MD_RD_DATA 8'h00, O_LOCK 0, FSM RESET, lock counter 0, O_ERR_CNT 0.
REQ-028 The same reset SHALL load the register file with: 0x0B=8'h01, 0x0C=8'h80, 0x11=8'h01, 0x12=8'h08, all others 8'h00.
REQ-029 Reset assertion mid-access SHALL discard the pending write or read.

Configuration
REQ-030 With MDRP_RESP_ERRCHK_EN defined, O_ERR_CNT SHALL increment, saturating at 255, on each cycle with OPC=11, with OPC=01 at addr>=0x20, or with INC while the pointer is 255.
REQ-031 Without MDRP_RESP_ERRCHK_EN, O_ERR_CNT SHALL be constant 8'h00 and no error logic SHALL be synthesized.

Structure
REQ-032 Package mdrp_pkg SHALL hold the opcode constants, register index constants (0x0B, 0x0C, 0x11, 0x12) and the reset-default table.
REQ-033 The lock FSM and counter SHALL be the sub-module mdrp_lock_model, taking I_PLL_RST, a write strobe and ICP[2:0], and producing lock.

Verification
REQ-034 Scenario: reset, INC x11, OPC=10 -> O_MD_RD_DATA=8'h01 one cycle later.
REQ-035 Scenario: at addr 0x11, OPC=01 data 8'h07, then OPC=10 -> 8'h07; drop I_PLL_RST -> O_LOCK=1 exactly LOCK_DELAY cycles later.
REQ-036 Scenario: write 0x11=8'h01 with GOOD_MASK=8'h88, release PLL reset -> O_LOCK stays 0 (FAIL); reassert I_PLL_RST -> FSM RESET.
REQ-037 Scenario: INC together with OPC=01 at addr 5, data 8'hA5 -> reg[5]=8'hA5 and address=6.
REQ-038 Scenario: while LOCKED, assert I_PLL_RST -> O_LOCK=0 next cycle and address=0.
REQ-039 Scenario: with MDRP_RESP_ERRCHK_EN, OPC=11 x3 plus a write at addr 0x40 -> O_ERR_CNT=4; without the macro -> 0.

Source files
------------

// File: rtl/mdrp_pkg.sv
// Shared constants for the MDRP responder: opcodes, register indices,
// lock FSM state encoding and the register-file power-on table.
package mdrp_pkg;

    localparam logic [1:0] OPC_NOP = 2'b00;
    localparam logic [1:0] OPC_WR  = 2'b01;
    localparam logic [1:0] OPC_RD  = 2'b10;
    localparam logic [1:0] OPC_ILL = 2'b11;

    localparam int REG_NUM = 32;

    localparam logic [4:0] REG_IDX_0B  = 5'h0B;
    localparam logic [4:0] REG_IDX_0C  = 5'h0C;
    localparam logic [4:0] REG_IDX_ICP = 5'h11;
    localparam logic [4:0] REG_IDX_12  = 5'h12;

    typedef enum logic [1:0] {
        LOCK_RESET  = 2'd0,
        LOCK_COUNT  = 2'd1,
        LOCK_LOCKED = 2'd2,
        LOCK_FAIL   = 2'd3
    } lock_state_e;

    // Power-on contents of the register file.
    function automatic logic [7:0] reg_default(input logic [4:0] idx);
        logic [7:0] val;
        case (idx)
            REG_IDX_0B:  val = 8'h01;
            REG_IDX_0C:  val = 8'h80;
            REG_IDX_ICP: val = 8'h01;
            REG_IDX_12:  val = 8'h08;
            default:     val = 8'h00;
        endcase
        return val;
    endfunction

endpackage

// File: rtl/mdrp_lock_model.sv
// Behavioural PLL lock model: counts LOCK_DELAY cycles after reset release
// or after any register write, then locks only if the ICP code is good.
module mdrp_lock_model
    import mdrp_pkg::*;
#(
    parameter int         LOCK_DELAY = 1000,
    parameter logic [7:0] GOOD_MASK  = 8'h88
) (
    input  logic       i_clk,
    input  logic       i_rst_n,
    input  logic       i_pll_rst,
    input  logic       i_wr,
    input  logic [2:0] i_icp,
    output logic       o_lock
);

    localparam int CW = $clog2(LOCK_DELAY + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(LOCK_DELAY - 1);
    localparam logic [CW-1:0] CNT_MAX  = '1;

    lock_state_e   r_state;
    lock_state_e   w_state_next;
    logic [CW-1:0] r_cnt;
    logic [CW-1:0] w_cnt_next;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state <= LOCK_RESET;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_next;
            r_cnt   <= w_cnt_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_cnt_next   = r_cnt;
        if (i_pll_rst) begin
            w_state_next = LOCK_RESET;
            w_cnt_next   = '0;
        end else begin
            case (r_state)
                LOCK_RESET: begin
                    w_state_next = LOCK_COUNT;
                    w_cnt_next   = '0;
                end
                LOCK_COUNT: begin
                    if (i_wr) begin
                        w_cnt_next = '0;
                    end else if (r_cnt == CNT_LAST) begin
                        w_state_next = GOOD_MASK[i_icp] ? LOCK_LOCKED : LOCK_FAIL;
                    end else if (r_cnt != CNT_MAX) begin
                        w_cnt_next = r_cnt + CW'(1);
                    end
                end
                LOCK_LOCKED, LOCK_FAIL: begin
                    // Any reconfiguration write forces a fresh lock attempt.
                    if (i_wr) begin
                        w_state_next = LOCK_COUNT;
                        w_cnt_next   = '0;
                    end
                end
                default: w_state_next = LOCK_RESET;
            endcase
        end
    end

    assign o_lock = (r_state == LOCK_LOCKED);

endmodule

// File: rtl/mdrp_responder.sv
// MDRP-style register responder with auto-increment pointer and PLL lock model.
// Optional protocol error counter enabled by defining MDRP_RESP_ERRCHK_EN.
module mdrp_responder
    import mdrp_pkg::*;
#(
    parameter int         LOCK_DELAY = 1000,
    parameter logic [7:0] GOOD_MASK  = 8'h88
) (
    input  logic       I_MD_CLK,
    input  logic       I_RST_N,
    input  logic       I_PLL_RST,
    input  logic       I_MD_INC,
    input  logic [1:0] I_MD_OPC,
    input  logic [7:0] I_MD_WR_DATA,
    output logic [7:0] O_MD_RD_DATA,
    output logic       O_LOCK,
    output logic [7:0] O_ERR_CNT
);

    logic [7:0] r_addr;
    logic       r_pll_rst_prev;
    logic [7:0] r_rd_data;
    logic [7:0] r_regs [REG_NUM];

    logic w_wr;
    logic w_rd;
    logic w_in_range;
    logic w_pll_chg;

    assign w_wr       = (I_MD_OPC == OPC_WR);
    assign w_rd       = (I_MD_OPC == OPC_RD);
    assign w_in_range = (r_addr < 8'(REG_NUM));
    assign w_pll_chg  = (I_PLL_RST != r_pll_rst_prev);

    // A PLL reset edge in either direction re-homes the pointer, even over INC.
    always_ff @(posedge I_MD_CLK or negedge I_RST_N) begin
        if (!I_RST_N) begin
            r_addr         <= 8'h00;
            r_pll_rst_prev <= 1'b1;
        end else begin
            r_pll_rst_prev <= I_PLL_RST;
            if (w_pll_chg) begin
                r_addr <= 8'h00;
            end else if (I_MD_INC) begin
                r_addr <= r_addr + 8'd1;
            end
        end
    end

    always_ff @(posedge I_MD_CLK or negedge I_RST_N) begin
        if (!I_RST_N) begin
            for (int i = 0; i < REG_NUM; i++) begin
                r_regs[i] <= reg_default(5'(i));
            end
        end else if (w_wr && w_in_range) begin
            r_regs[r_addr[4:0]] <= I_MD_WR_DATA;
        end
    end

    always_ff @(posedge I_MD_CLK or negedge I_RST_N) begin
        if (!I_RST_N) begin
            r_rd_data <= 8'h00;
        end else if (w_rd) begin
            r_rd_data <= w_in_range ? r_regs[r_addr[4:0]] : 8'h00;
        end
    end

    assign O_MD_RD_DATA = r_rd_data;

    mdrp_lock_model #(
        .LOCK_DELAY (LOCK_DELAY),
        .GOOD_MASK  (GOOD_MASK)
    ) u_lock (
        .i_clk     (I_MD_CLK),
        .i_rst_n   (I_RST_N),
        .i_pll_rst (I_PLL_RST),
        .i_wr      (w_wr),
        .i_icp     (r_regs[REG_IDX_ICP][2:0]),
        .o_lock    (O_LOCK)
    );

`ifdef MDRP_RESP_ERRCHK_EN
    logic [7:0] r_err_cnt;
    logic       w_err;

    assign w_err = (I_MD_OPC == OPC_ILL) || (w_wr && !w_in_range) ||
                   (I_MD_INC && (r_addr == 8'hFF));

    always_ff @(posedge I_MD_CLK or negedge I_RST_N) begin
        if (!I_RST_N) begin
            r_err_cnt <= 8'h00;
        end else if (w_err && (r_err_cnt != 8'hFF)) begin
            r_err_cnt <= r_err_cnt + 8'd1;
        end
    end

    assign O_ERR_CNT = r_err_cnt;
`else
    assign O_ERR_CNT = 8'h00;
`endif

endmodule

// File: tb/tb_mdrp_responder.sv
// Directed bench for mdrp_responder with a cycle-level reference model and
// literal checkpoints; honours MDRP_RESP_ERRCHK_EN for the error counter.
module tb_mdrp_responder;

    localparam int         LOCK_DELAY = 12;
    localparam logic [7:0] GOOD_MASK  = 8'h88;

    logic       clk;
    logic       I_RST_N;
    logic       I_PLL_RST;
    logic       I_MD_INC;
    logic [1:0] I_MD_OPC;
    logic [7:0] I_MD_WR_DATA;
    logic [7:0] O_MD_RD_DATA;
    logic       O_LOCK;
    logic [7:0] O_ERR_CNT;

    mdrp_responder #(
        .LOCK_DELAY (LOCK_DELAY),
        .GOOD_MASK  (GOOD_MASK)
    ) dut (
        .I_MD_CLK     (clk),
        .I_RST_N      (I_RST_N),
        .I_PLL_RST    (I_PLL_RST),
        .I_MD_INC     (I_MD_INC),
        .I_MD_OPC     (I_MD_OPC),
        .I_MD_WR_DATA (I_MD_WR_DATA),
        .O_MD_RD_DATA (O_MD_RD_DATA),
        .O_LOCK       (O_LOCK),
        .O_ERR_CNT    (O_ERR_CNT)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int n_checks = 0;
    int n_errors = 0;
    bit chk_on   = 1'b0;

    // Reference model state
    logic [7:0] m_regs [32];
    int         m_addr;
    logic [7:0] m_rd;
    int         m_err;
    int         m_since;      // cycles since COUNT was (re)entered, -1 while PLL held in reset
    logic       m_lock;
    logic       m_pll_prev;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at t=%0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 32; i++) m_regs[i] = 8'h00;
        m_regs[11] = 8'h01;
        m_regs[12] = 8'h80;
        m_regs[17] = 8'h01;
        m_regs[18] = 8'h08;
        m_addr     = 0;
        m_rd       = 8'h00;
        m_err      = 0;
        m_since    = -1;
        m_lock     = 1'b0;
        m_pll_prev = 1'b1;
    endtask

    // Applies one clock edge worth of the spec's rules to the model.
    task automatic model_update();
        bit wr;
        bit rd;
        wr = (I_MD_OPC == 2'b01);
        rd = (I_MD_OPC == 2'b10);
`ifdef MDRP_RESP_ERRCHK_EN
        if ((I_MD_OPC == 2'b11) || (wr && m_addr >= 32) || (I_MD_INC && m_addr == 255))
            m_err = (m_err < 255) ? m_err + 1 : 255;
`endif
        if (rd) m_rd = (m_addr < 32) ? m_regs[m_addr] : 8'h00;
        if (I_PLL_RST) begin
            m_since = -1;
            m_lock  = 1'b0;
        end else if (m_since < 0 || wr) begin
            m_since = 0;
            m_lock  = 1'b0;
        end else begin
            m_since++;
            if (m_since == LOCK_DELAY) m_lock = GOOD_MASK[m_regs[17][2:0]];
        end
        if (wr && m_addr < 32) m_regs[m_addr] = I_MD_WR_DATA;
        if (I_PLL_RST !== m_pll_prev) m_addr = 0;
        else if (I_MD_INC) m_addr = (m_addr + 1) % 256;
        m_pll_prev = I_PLL_RST;
    endtask

    always @(negedge clk) begin
        if (chk_on && I_RST_N) begin
            check("rd_data", O_MD_RD_DATA, m_rd);
            check("lock", O_LOCK, m_lock);
            check("err_cnt", O_ERR_CNT, m_err[7:0]);
        end
    end

    task automatic step(input logic inc, input logic [1:0] opc, input logic [7:0] d);
        I_MD_INC     = inc;
        I_MD_OPC     = opc;
        I_MD_WR_DATA = d;
        @(posedge clk);
        model_update();
        @(negedge clk);
        $display("t=%0t pll=%0b inc=%0b opc=%0d wd=%02h -> rd=%02h lock=%0b err=%0d",
                 $time, I_PLL_RST, inc, opc, d, O_MD_RD_DATA, O_LOCK, O_ERR_CNT);
        I_MD_INC = 1'b0;
        I_MD_OPC = 2'b00;
    endtask

    task automatic incs(input int n);
        for (int i = 0; i < n; i++) step(1'b1, 2'b00, 8'h00);
    endtask

    task automatic wait_lock(input string name);
        int n;
        n = 0;
        while (!O_LOCK && n < LOCK_DELAY + 8) begin
            step(1'b0, 2'b00, 8'h00);
            n++;
        end
        check(name, n, LOCK_DELAY);
    endtask

    int exp_err;

    initial begin
        I_RST_N      = 1'b0;
        I_PLL_RST    = 1'b1;
        I_MD_INC     = 1'b0;
        I_MD_OPC     = 2'b00;
        I_MD_WR_DATA = 8'h00;
        model_reset();
        repeat (3) @(negedge clk);
        I_RST_N = 1'b1;
        chk_on  = 1'b1;
        check("reset_rd", O_MD_RD_DATA, 8'h00);
        check("reset_lock", O_LOCK, 1'b0);
        check("reset_err", O_ERR_CNT, 8'h00);

        // Marker at reg0, INC+write at addr 5, then default reads
        step(1'b0, 2'b01, 8'h5A);
        incs(5);
        step(1'b1, 2'b01, 8'hA5);
        incs(5);
        step(1'b0, 2'b10, 8'h00);
        check("read_0x0B", O_MD_RD_DATA, 8'h01);
        step(1'b1, 2'b00, 8'h00);
        step(1'b0, 2'b10, 8'h00);
        check("read_0x0C", O_MD_RD_DATA, 8'h80);

        // Good ICP code, then release PLL reset and time the lock
        incs(5);
        step(1'b0, 2'b01, 8'h07);
        step(1'b0, 2'b10, 8'h00);
        check("read_icp_07", O_MD_RD_DATA, 8'h07);
        I_PLL_RST = 1'b0;
        step(1'b0, 2'b00, 8'h00);
        wait_lock("lock_delay_good");

        // PLL reset while locked drops lock and re-homes the pointer
        incs(3);
        I_PLL_RST = 1'b1;
        step(1'b0, 2'b00, 8'h00);
        check("lock_drop", O_LOCK, 1'b0);
        step(1'b0, 2'b10, 8'h00);
        check("addr_cleared", O_MD_RD_DATA, 8'h5A);

        // Bad ICP code: counting ends in failure
        incs(17);
        step(1'b0, 2'b01, 8'h01);
        I_PLL_RST = 1'b0;
        step(1'b0, 2'b00, 8'h00);
        incs(5);
        step(1'b0, 2'b10, 8'h00);
        check("read_inc_wr", O_MD_RD_DATA, 8'hA5);
        repeat (LOCK_DELAY + 2) step(1'b0, 2'b00, 8'h00);
        check("bad_icp_nolock", O_LOCK, 1'b0);

        // Back to RESET, fix ICP while held, release again
        I_PLL_RST = 1'b1;
        step(1'b0, 2'b00, 8'h00);
        incs(17);
        step(1'b0, 2'b01, 8'h07);
        I_PLL_RST = 1'b0;
        step(1'b0, 2'b00, 8'h00);
        wait_lock("lock_after_fail");

        // Any write while locked restarts the count
        step(1'b0, 2'b01, 8'h5A);
        check("wr_unlock", O_LOCK, 1'b0);
        wait_lock("relock_after_wr");

        // Read hold, out-of-range accesses and protocol errors
        step(1'b0, 2'b10, 8'h00);
        step(1'b0, 2'b00, 8'h00);
        check("hold_nop", O_MD_RD_DATA, 8'h5A);
        incs(64);
        step(1'b0, 2'b01, 8'hFF);
        repeat (3) step(1'b0, 2'b11, 8'h00);
        check("hold_illegal", O_MD_RD_DATA, 8'h5A);
`ifdef MDRP_RESP_ERRCHK_EN
        exp_err = 4;
`else
        exp_err = 0;
`endif
        check("err_four", O_ERR_CNT, exp_err);
        step(1'b0, 2'b10, 8'h00);
        check("read_oor", O_MD_RD_DATA, 8'h00);

        // Pointer wrap 255 -> 0
        incs(191);
        step(1'b1, 2'b00, 8'h00);
        step(1'b0, 2'b10, 8'h00);
        check("wrap_read", O_MD_RD_DATA, 8'h5A);
        check("err_wrap", O_ERR_CNT, exp_err == 0 ? 0 : 5);

        // Error counter saturation
        repeat (260) step(1'b0, 2'b11, 8'h00);
        check("err_sat", O_ERR_CNT, exp_err == 0 ? 8'h00 : 8'hFF);

        // Reset asserted mid-write
        I_MD_OPC     = 2'b01;
        I_MD_WR_DATA = 8'h33;
        #2;
        I_RST_N   = 1'b0;
        I_PLL_RST = 1'b1;
        @(posedge clk);
        @(negedge clk);
        I_MD_OPC = 2'b00;
        model_reset();
        I_RST_N = 1'b1;
        check("rst2_rd", O_MD_RD_DATA, 8'h00);
        check("rst2_lock", O_LOCK, 1'b0);
        check("rst2_err", O_ERR_CNT, 8'h00);
        step(1'b0, 2'b10, 8'h00);
        check("rst2_reg0", O_MD_RD_DATA, 8'h00);
        incs(17);
        step(1'b0, 2'b10, 8'h00);
        check("rst2_icp", O_MD_RD_DATA, 8'h01);
        step(1'b1, 2'b00, 8'h00);
        step(1'b0, 2'b10, 8'h00);
        check("rst2_0x12", O_MD_RD_DATA, 8'h08);

        chk_on = 1'b0;
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
